// File: rtl/pwm_pkg.sv
// pwm_pkg: address offsets, ctrl bit indices and counting mode shared by pwm_multichannel
package pwm_pkg;
    typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} mode_t;
    localparam int OFS_PERIOD  = 0;
    localparam int OFS_PRESC   = 1;
    localparam int OFS_CTRL    = 2;
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CENTER = 1;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/active duty, compare against the shared counter and output gating
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en_out,
    input  logic             en_pwm,
    output logic             out
);
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] duty_act;
    logic             pwm;
    assign pwm = run && ((cnt < duty_act) || (&duty_act));
    // shadow capture, boundary copy with same-cycle write bypass, registered gated output
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (wr) duty_sh <= wr_data;
            if (load) duty_act <= wr ? wr_data : duty_sh;
            out <= en_out && (en_pwm ? pwm : 1'b1);
        end
    end
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared prescaler/counter and config decode driving NUM_CH PWM channels; PWM_CENTER_ALIGN_EN adds center-aligned counting
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = $clog2(NUM_CH + 3)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    output logic [NUM_CH-1:0] out,
    output logic              period_end
);
    logic [31:0]       addr;
    logic [CNT_W-1:0]  presc;
    logic [CNT_W-1:0]  presc_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  period_act;
    logic              run;
    logic              tick;
    logic              load;
    logic              restart;
    logic              hit_period;
    logic              hit_presc;
    logic              hit_ctrl;
    logic [NUM_CH-1:0] hit_duty;
`ifdef PWM_CENTER_ALIGN_EN
    mode_t             mode;
    logic              down;
    logic              down_nx;
`endif
    assign addr       = 32'(wr_addr);
    assign hit_period = wr_en && addr == NUM_CH + OFS_PERIOD;
    assign hit_presc  = wr_en && addr == NUM_CH + OFS_PRESC;
    assign hit_ctrl   = wr_en && addr == NUM_CH + OFS_CTRL;
    assign restart    = hit_ctrl && wr_data[CTRL_RUN] && !run;
    assign tick       = run && presc_cnt == presc;
    assign period_end = !rst && tick && cnt_nx == '0;
    assign load       = period_end || !run;
    // next counter value on a tick; the period ends whenever this lands on zero
    always_comb begin
        cnt_nx = (cnt >= period_act) ? '0 : cnt + CNT_W'(1);
`ifdef PWM_CENTER_ALIGN_EN
        down_nx = 1'b0;
        if (mode == CENTER) begin
            cnt_nx  = down ? cnt - CNT_W'(1) :
                      (cnt < period_act) ? cnt + CNT_W'(1) :
                      (period_act == '0) ? '0 : period_act - CNT_W'(1);
            down_nx = (cnt_nx != '0) && (down || cnt >= period_act);
        end
`endif
    end
    // config registers, prescaler and counter; a run 0->1 write restarts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            presc_cnt  <= '0;
            cnt        <= '0;
            run        <= 1'b0;
            period_sh  <= '1;
            period_act <= '1;
`ifdef PWM_CENTER_ALIGN_EN
            mode       <= EDGE;
            down       <= 1'b0;
`endif
        end else begin
            if (hit_period) period_sh <= wr_data;
            if (load) period_act <= hit_period ? wr_data : period_sh;
            if (hit_presc) presc <= wr_data;
            if (hit_ctrl) run <= wr_data[CTRL_RUN];
            presc_cnt <= (hit_presc || restart || tick || !run) ? '0 : presc_cnt + CNT_W'(1);
            cnt       <= restart ? '0 : tick ? cnt_nx : cnt;
`ifdef PWM_CENTER_ALIGN_EN
            if (hit_ctrl) mode <= wr_data[CTRL_CENTER] ? CENTER : EDGE;
            down <= restart ? 1'b0 : tick ? down_nx : down;
`endif
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign hit_duty[i] = wr_en && addr == i;
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr      (hit_duty[i]),
            .wr_data (wr_data),
            .load    (load),
            .run     (run),
            .cnt     (cnt),
            .en_out  (en_out[i]),
            .en_pwm  (en_pwm[i]),
            .out     (out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed and randomized checks of pwm_multichannel against a phase-based reference model
module tb_pwm_multichannel;
    localparam int NUM_CH = 16;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 5;
    localparam int ONES   = 255;
    localparam int A_PER  = NUM_CH;
    localparam int A_PRE  = NUM_CH + 1;
    localparam int A_CTRL = NUM_CH + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] out;
    logic              period_end;

    int checks = 0;
    int failures = 0;

    int m_dsh[NUM_CH];
    int m_dact[NUM_CH];
    int m_psh, m_pact, m_s, m_pc, m_t;
    bit m_run, m_center, m_valid;
    logic [NUM_CH-1:0] m_out;
    int hi_cnt[NUM_CH];
    int pe_cnt;
    bit last_pe;

    pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .en_out     (en_out),
        .en_pwm     (en_pwm),
        .out        (out),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_dsh[c] = 0;
            m_dact[c] = 0;
        end
        m_psh = ONES; m_pact = ONES; m_s = 0; m_pc = 0; m_t = 0;
        m_run = 0; m_center = 0; m_out = '0; m_valid = 1;
    endtask

    // one clock cycle: compare at negedge against the model, then advance the model
    task automatic step();
        int len, cv, wa;
        bit tick, pe, restart, old_run;
        logic [NUM_CH-1:0] pwm, nout;
        @(negedge clk);
        len  = m_center ? (m_pact == 0 ? 1 : 2 * m_pact) : m_pact + 1;
        cv   = (m_center && m_t > m_pact) ? 2 * m_pact - m_t : m_t;
        tick = !rst && m_run && m_pc == m_s;
        pe   = tick && (m_t + 1 == len);
        for (int c = 0; c < NUM_CH; c++) pwm[c] = m_run && (cv < m_dact[c] || m_dact[c] == ONES);
        nout = en_out & ((en_pwm & pwm) | ~en_pwm);
        if (m_valid) begin
            check("out", 32'(out), 32'(m_out));
            check("period_end", 32'(period_end), 32'(pe));
        end
        for (int c = 0; c < NUM_CH; c++) if (out[c]) hi_cnt[c]++;
        if (period_end) pe_cnt++;
        last_pe = period_end;
        if (rst) m_reset();
        else begin
            wa = int'(wr_addr);
            old_run = m_run;
            restart = wr_en && wa == A_CTRL && wr_data[0] && !old_run;
            if (pe || !old_run) begin
                m_pact = (wr_en && wa == A_PER) ? int'(wr_data) : m_psh;
                for (int c = 0; c < NUM_CH; c++) m_dact[c] = (wr_en && wa == c) ? int'(wr_data) : m_dsh[c];
            end
            m_pc = ((wr_en && wa == A_PRE) || restart || tick || !old_run) ? 0 : m_pc + 1;
            m_t  = restart ? 0 : tick ? (pe ? 0 : m_t + 1) : m_t;
            if (wr_en) begin
                if (wa < NUM_CH) m_dsh[wa] = int'(wr_data);
                if (wa == A_PER) m_psh = int'(wr_data);
                if (wa == A_PRE) m_s = int'(wr_data);
                if (wa == A_CTRL) begin
                    m_run = wr_data[0];
`ifdef PWM_CENTER_ALIGN_EN
                    m_center = wr_data[1];
`else
                    m_center = 0;
`endif
                end
            end
            m_out = nout;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(int n);
        repeat (n) step();
    endtask

    task automatic wr(int a, int d);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = CNT_W'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_cnt();
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
        pe_cnt = 0;
    endtask

    task automatic wait_pe();
        int k;
        k = 0;
        step();
        while (!last_pe && k < 600) begin
            step();
            k++;
        end
        check("wait_pe", 32'(last_pe), 1);
    endtask

    initial begin
        int p, s, len, d;
        m_valid = 0;
        m_out = '0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; en_out = '0; en_pwm = '0;
        @(posedge clk);
        #1;
        run_n(2);
        rst = 1'b0;
        check("rst_out", 32'(out), 0);
        check("rst_period_end", 32'(period_end), 0);
        check("rst_cnt", 32'(dut.cnt), 0);
        check("rst_period", 32'(dut.period_act), ONES);

        en_out = '1; en_pwm = '1;
        wr(0, 128);
        wr(A_CTRL, 1);
        run_n(10);
        clear_cnt();
        run_n(512);
        check("duty128_high", hi_cnt[0], 256);
        check("duty128_pe", pe_cnt, 2);

        wr(A_CTRL, 0);
        wr(A_PRE, 3);
        wr(A_PER, 9);
        wr(1, 5);
        wr(A_CTRL, 1);
        run_n(7);
        clear_cnt();
        run_n(80);
        check("presc3_high", hi_cnt[1], 40);
        check("presc3_pe", pe_cnt, 2);

        wr(2, 0);
        run_n(45);
        clear_cnt();
        run_n(40);
        check("duty0_high", hi_cnt[2], 0);
        wr(2, 255);
        run_n(45);
        clear_cnt();
        run_n(40);
        check("duty255_high", hi_cnt[2], 40);
        wr(2, 0);
        run_n(45);
        en_pwm[2] = 1'b0;
        run_n(2);
        clear_cnt();
        run_n(40);
        check("static_high", hi_cnt[2], 40);
        en_out[2] = 1'b0;
        run_n(2);
        clear_cnt();
        run_n(40);
        check("out_disabled", hi_cnt[2], 0);
        en_out[2] = 1'b1; en_pwm[2] = 1'b1;

        wr(A_CTRL, 0);
        wr(A_PRE, 0);
        wr(A_PER, 255);
        wr(3, 64);
        wr(A_CTRL, 1);
        run_n(100);
        wr(3, 192);
        wait_pe();
        clear_cnt();
        run_n(256);
        check("midwrite_new_ratio", hi_cnt[3], 192);
        run_n(255);
        wr(3, 64);
        check("write_in_pe_cycle", 32'(last_pe), 1);
        clear_cnt();
        run_n(256);
        check("pe_cycle_write_ratio", hi_cnt[3], 64);

        for (int r = 0; r < 6; r++) begin
            wr(A_CTRL, 0);
            p = (r == 0) ? 0 : int'($urandom_range(1, 20));
            s = int'($urandom_range(0, 3));
            wr(A_PRE, s);
            wr(A_PER, p);
            for (int c = 0; c < NUM_CH; c++) begin
                d = int'($urandom_range(0, 3));
                wr(c, d == 0 ? 0 : d == 1 ? ONES : int'($urandom_range(0, p + 2)));
            end
            en_out = NUM_CH'($urandom);
            en_pwm = NUM_CH'($urandom);
            wr(A_CTRL, 1);
            len = (p + 1) * (s + 1);
            run_n(len + int'($urandom_range(0, len)));
            wr(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, p + 1)));
            wr(A_PER, int'($urandom_range(1, 20)));
            wr(int'($urandom_range(A_CTRL + 1, 31)), int'($urandom_range(0, ONES)));
            en_out = NUM_CH'($urandom);
            run_n(3 * len + 8);
        end
        en_out = '1; en_pwm = '1;

`ifdef PWM_CENTER_ALIGN_EN
        wr(A_CTRL, 0);
        wr(A_PRE, 0);
        wr(A_PER, 4);
        wr(4, 2);
        wr(A_CTRL, 3);
        run_n(4);
        clear_cnt();
        run_n(80);
        check("center_pe", pe_cnt, 10);
        wr(A_CTRL, 0);
`endif

        wr(A_CTRL, 0);
        wr(A_PRE, 0);
        wr(A_PER, 255);
        wr(A_CTRL, 1);
        wait_pe();
        run_n(100);
        check("cnt_at_100", 32'(dut.cnt), 100);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'd7;
        step();
        rst = 1'b0;
        wr_en = 1'b0;
        check("midrst_out", 32'(out), 0);
        check("midrst_pe", 32'(period_end), 0);
        check("midrst_cnt", 32'(dut.cnt), 0);
        check("midrst_period", 32'(dut.period_act), ONES);
        check("midrst_duty0", 32'(dut.g_ch[0].u_ch.duty_act), 0);
        check("midrst_duty3", 32'(dut.g_ch[3].u_ch.duty_act), 0);
        run_n(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
